// File: rtl/mul3_arb_seq.sv
// mul3_arb_seq: two-requester arbiter feeding a 3x3-bit shift-and-add multiplier.
// One partial-product row per cycle, so a result appears 3 cycles after accept
// and is held until the consumer takes it.
// Optional build macro: MUL3_ARB_RR_EN selects round-robin arbitration;
// when it is undefined, requester 0 has fixed priority.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. reqN_ready depends combinationally on reqN_valid (IDLE only), and a
// requester may drop valid before it is granted. resp_valid, resp_id and
// resp_prod hold steady until resp_ready is seen high at an edge.
module mul3_arb_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  input  logic [2:0] req0_a,
  input  logic [2:0] req0_b,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [2:0] req1_a,
  input  logic [2:0] req1_b,
  output logic       req1_ready,
  output logic       resp_valid,
  output logic       resp_id,
  output logic [5:0] resp_prod,
  input  logic       resp_ready,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;
  logic [2:0] a_q;
  logic [2:0] b_q;
  logic       id_q;
  logic [5:0] acc;
  logic [1:0] row;
  logic       grant;
  logic       accept;
  logic       b_bit;
  logic [5:0] pp_row;

`ifdef MUL3_ARB_RR_EN
  logic last_grant;

  // Round-robin: on a tie, the requester that was not served last wins.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else                          grant = req1_valid;
  end

  // Remember who was served by the most recent accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_grant <= 1'b1;
    else if (accept) last_grant <= grant;
  end
`else
  // Fixed priority: requester 0 wins any tie.
  always_comb begin
    grant = 1'b0;
    if (req0_valid) grant = 1'b0;
    else            grant = req1_valid;
  end
`endif

  assign accept     = (state == IDLE) && (req0_valid || req1_valid);
  assign req0_ready = (state == IDLE) && req0_valid && !grant;
  assign req1_ready = (state == IDLE) && req1_valid && grant;

  // Pick the multiplier bit for the current row and form the shifted row.
  always_comb begin
    b_bit = 1'b0;
    case (row)
      2'd0:    b_bit = b_q[0];
      2'd1:    b_bit = b_q[1];
      2'd2:    b_bit = b_q[2];
      default: b_bit = 1'b0;
    endcase
  end

  assign pp_row = {3'b000, a_q & {3{b_bit}}} << row;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; the unused encoding falls back to IDLE.
  always_comb begin
    state_nxt = IDLE;
    case (state)
      IDLE:    state_nxt = accept ? MUL : IDLE;
      MUL:     state_nxt = (row == 2'd2) ? DONE : MUL;
      DONE:    state_nxt = resp_ready ? IDLE : DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture on accept, then one accumulate step per MUL cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q  <= 3'd0;
      b_q  <= 3'd0;
      id_q <= 1'b0;
      acc  <= 6'd0;
      row  <= 2'd0;
    end else if (accept) begin
      a_q  <= grant ? req1_a : req0_a;
      b_q  <= grant ? req1_b : req0_b;
      id_q <= grant;
      acc  <= 6'd0;
      row  <= 2'd0;
    end else if (state == MUL) begin
      acc <= acc + pp_row;
      row <= row + 2'd1;
    end
  end

  assign resp_valid = (state == DONE);
  assign resp_prod  = acc;
  assign resp_id    = id_q;
  assign busy       = (state != IDLE);
  assign state_dbg  = state;

endmodule

// File: doc/mul3_arb_seq.md
MUL3_ARB_SEQ -- requirements
Module: mul3_arb_seq

Interface
- REQ-001: clk  input  1  single clock; all state updates on rising edge.
- REQ-002: rst  input  1  reset, asynchronous, active-high.
- REQ-003: req0_valid  input  1  requester 0 has operands pending.
- REQ-004: req0_a, req0_b  input  3 each  requester 0 unsigned operands.
- REQ-005: req0_ready  output  1  requester 0 operands accepted this cycle.
- REQ-006: req1_valid, req1_a, req1_b, req1_ready  same as REQ-003..005 for requester 1.
- REQ-007: resp_valid  output  1  result available.
- REQ-008: resp_id  output  1  requester index owning the result.
- REQ-009: resp_prod  output  6  unsigned product a*b.
- REQ-010: resp_ready  input  1  consumer accepts result.
- REQ-011: busy  output  1  high in any state other than IDLE.

Function
- REQ-012: FSM states IDLE, MUL, DONE, encoded in 2 bits; the fourth encoding returns to IDLE on the next edge.
- REQ-013: IDLE: reqN_ready = 1 only for the granted requester, combinationally, when any reqN_valid = 1; both ready = 0 in MUL and DONE.
- REQ-014: Handshake: reqN_valid & reqN_ready at an edge captures a/b and the grant ID, clears acc and the row counter, and moves the FSM to MUL.
- REQ-015: MUL: one partial-product row per cycle; at row k (0..2), acc <= acc + ((a & {3{b[k]}}) << k); after row 2 the FSM moves to DONE.
- REQ-016: Arithmetic: acc is 6 bits; maximum 7*7=49, so no overflow is possible and no truncation is allowed.
- REQ-017: Latency: resp_valid rises exactly 3 cycles after the accepting edge; resp_prod and resp_id stay stable while resp_valid = 1.
- REQ-018: DONE: resp_valid = 1 until resp_valid & resp_ready at an edge, then IDLE; a new accept cannot occur before the following cycle, so the minimum issue interval is 5 cycles.
- REQ-019: Operand or valid changes on req inputs after the accept have no effect on the in-flight operation.
- REQ-020: Arbitration happens only in IDLE; a requester that is not granted keeps its ready low and waits. Dropping valid before grant is legal.
- REQ-021: resp_ready asserted while not in DONE is ignored.
- REQ-022: b = 0 or a = 0 yields resp_prod = 0 with the same 3-cycle latency; there is no early termination.

Reset
- REQ-023: rst = 1 forces, asynchronously: state = IDLE, acc = 0, row counter = 0, resp_valid = 0, resp_prod = 0, resp_id = 0, busy = 0, last_grant = 1.
- REQ-024: Reset in MUL or DONE aborts the operation; no response is issued for it after reset is released.
- REQ-025: The first accept after reset may occur in the first cycle with rst = 0.

Configuration
- REQ-026: Macro MUL3_ARB_RR_EN defined: round-robin arbitration. On a simultaneous request, grant goes to the requester other than last_grant; last_grant updates at each accept.
- REQ-027: MUL3_ARB_RR_EN undefined: fixed priority, requester 0 always wins a simultaneous request; last_grant is not implemented.
- REQ-028: All other behaviour is identical in both builds.

Verification
- REQ-029: Single op: req0 a=7, b=7 accepted at edge N -> resp_valid=1 after edge N+3, resp_prod=49, resp_id=0.
- REQ-030: Simultaneous: req0 (3,5) and req1 (6,2) held valid; with RR_EN -> responses 15 (id 0) then 12 (id 1); without RR_EN and both held continuously -> repeated id 0 only.
- REQ-031: Backpressure: resp_ready=0 for 10 cycles with result 4*6=24 -> resp_valid, resp_prod=24 and busy held; both req*_ready=0 throughout.
- REQ-032: Operand change: a=5, b=3 accepted, then inputs changed to 0 the next cycle -> resp_prod=15.
- REQ-033: Reset abort: rst pulsed during the second MUL cycle of 6*6 -> outputs zero immediately; no response with value 36 appears.
- REQ-034: Zero and one cases: (0,7) -> 0; (7,1) -> 7; (1,4) -> 4; each with 3-cycle latency.
